// File: rtl/csr_trap_unit.sv
// Machine-mode CSR file and trap-state sequencer.
// Supplies the trap/mret redirect targets and the 64-bit cycle/instret counters.
module csr_trap_unit #(
  parameter logic [31:0] MTVEC_RESET = 32'h0000_0100,
  parameter logic [31:0] HART_ID     = 32'd0,
  parameter logic [31:0] MISA_VALUE  = 32'h4000_0100
) (
  input  logic        clk_i,
  input  logic        rst_i,
  input  logic        csr_access_i,
  input  logic [1:0]  csr_op_i,
  input  logic [11:0] csr_addr_i,
  input  logic [31:0] csr_wdata_i,
  output logic [31:0] csr_rdata_o,
  output logic        csr_illegal_o,
  input  logic        save_pc_ex_i,
  input  logic        save_pc_id_i,
  input  logic [31:0] pc_ex_i,
  input  logic [31:0] pc_id_i,
  input  logic [4:0]  exception_cause_i,
  input  logic        is_mret_i,
  input  logic        instr_retired_i,
  output logic [31:0] trap_vector_o,
  output logic [31:0] mepc_o,
  output logic        mie_o
);

  localparam logic [11:0] A_MSTATUS   = 12'h300;
  localparam logic [11:0] A_MISA      = 12'h301;
  localparam logic [11:0] A_MTVEC     = 12'h305;
  localparam logic [11:0] A_MSCRATCH  = 12'h340;
  localparam logic [11:0] A_MEPC      = 12'h341;
  localparam logic [11:0] A_MCAUSE    = 12'h342;
  localparam logic [11:0] A_MCYCLE    = 12'hB00;
  localparam logic [11:0] A_MINSTRET  = 12'hB02;
  localparam logic [11:0] A_MCYCLEH   = 12'hB80;
  localparam logic [11:0] A_MINSTRETH = 12'hB82;
  localparam logic [11:0] A_CYCLE     = 12'hC00;
  localparam logic [11:0] A_INSTRET   = 12'hC02;
  localparam logic [11:0] A_CYCLEH    = 12'hC80;
  localparam logic [11:0] A_INSTRETH  = 12'hC82;
  localparam logic [11:0] A_MHARTID   = 12'hF14;

  logic        mie, mpie;
  logic [31:2] mtvec, mepc;
  logic [31:0] mscratch;
  logic [4:0]  mcause;
  logic [63:0] mcycle, minstret;

  logic        mapped, trap, csr_we;
  logic [31:0] wval;
  logic [63:0] mcycle_next, minstret_next;
  logic        unused_pc_lsbs;

  assign unused_pc_lsbs = ^{pc_ex_i[1:0], pc_id_i[1:0], MTVEC_RESET[1:0]};

  always_comb begin
    mapped      = 1'b1;
    csr_rdata_o = '0;
    case (csr_addr_i)
      A_MSTATUS:                csr_rdata_o = {19'b0, 2'b11, 3'b0, mpie, 3'b0, mie, 3'b0};
      A_MISA:                   csr_rdata_o = MISA_VALUE;
      A_MTVEC:                  csr_rdata_o = {mtvec, 2'b00};
      A_MSCRATCH:               csr_rdata_o = mscratch;
      A_MEPC:                   csr_rdata_o = {mepc, 2'b00};
      A_MCAUSE:                 csr_rdata_o = {27'b0, mcause};
      A_MCYCLE, A_CYCLE:        csr_rdata_o = mcycle[31:0];
      A_MCYCLEH, A_CYCLEH:      csr_rdata_o = mcycle[63:32];
      A_MINSTRET, A_INSTRET:    csr_rdata_o = minstret[31:0];
      A_MINSTRETH, A_INSTRETH:  csr_rdata_o = minstret[63:32];
      A_MHARTID:                csr_rdata_o = HART_ID;
      default:                  mapped = 1'b0;
    endcase
  end

  assign csr_illegal_o = csr_access_i &&
                         (!mapped || (csr_op_i != 2'b00 && csr_addr_i[11:10] == 2'b11));
  assign trap   = save_pc_ex_i || save_pc_id_i;
  assign csr_we = csr_access_i && !csr_illegal_o && csr_op_i != 2'b00 && !trap && !is_mret_i;

  always_comb begin
    case (csr_op_i)
      2'b01:   wval = csr_wdata_i;
      2'b10:   wval = csr_rdata_o | csr_wdata_i;
      2'b11:   wval = csr_rdata_o & ~csr_wdata_i;
      default: wval = csr_rdata_o;
    endcase
  end

  // A half-write overlays the already-incremented value so carries into the other half survive.
  always_comb begin
    mcycle_next   = mcycle + 64'd1;
    minstret_next = minstret + {63'b0, instr_retired_i && !trap};
    if (csr_we) begin
      case (csr_addr_i)
        A_MCYCLE:    mcycle_next[31:0]    = wval;
        A_MCYCLEH:   mcycle_next[63:32]   = wval;
        A_MINSTRET:  minstret_next[31:0]  = wval;
        A_MINSTRETH: minstret_next[63:32] = wval;
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      mie      <= 1'b0;
      mpie     <= 1'b0;
      mtvec    <= MTVEC_RESET[31:2];
      mscratch <= '0;
      mepc     <= '0;
      mcause   <= '0;
      mcycle   <= '0;
      minstret <= '0;
    end else begin
      mcycle   <= mcycle_next;
      minstret <= minstret_next;
      if (trap) begin
        mepc   <= save_pc_ex_i ? pc_ex_i[31:2] : pc_id_i[31:2];
        mcause <= exception_cause_i;
        mpie   <= mie;
        mie    <= 1'b0;
      end else if (is_mret_i) begin
        mie  <= mpie;
        mpie <= 1'b1;
      end else if (csr_we) begin
        case (csr_addr_i)
          A_MSTATUS: begin
            mie  <= wval[3];
            mpie <= wval[7];
          end
          A_MTVEC:    mtvec    <= wval[31:2];
          A_MSCRATCH: mscratch <= wval;
          A_MEPC:     mepc     <= wval[31:2];
          A_MCAUSE:   mcause   <= wval[4:0];
          default: ;
        endcase
      end
    end
  end

  assign trap_vector_o = {mtvec, 2'b00};
  assign mepc_o        = {mepc, 2'b00};
  assign mie_o         = mie;

endmodule

// File: tb/tb_csr_trap_unit.sv
// Scoreboard bench for csr_trap_unit: a behavioural CSR model predicts every
// cycle's outputs, a monitor compares them at the falling edge.
module tb_csr_trap_unit;

  localparam logic [31:0] HART = 32'd5;
  localparam logic [31:0] MISA = 32'h4000_0100;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        csr_access = 1'b0;
  logic [1:0]  csr_op = '0;
  logic [11:0] csr_addr = '0;
  logic [31:0] csr_wdata = '0;
  logic [31:0] csr_rdata;
  logic        csr_illegal;
  logic        save_ex = 1'b0, save_id = 1'b0;
  logic [31:0] pc_ex = '0, pc_id = '0;
  logic [4:0]  cause = '0;
  logic        mret = 1'b0, retired = 1'b0;
  logic [31:0] trap_vector, mepc;
  logic        mie;

  always #5 clk = ~clk;

  csr_trap_unit #(.MTVEC_RESET(32'h0000_0100), .HART_ID(HART), .MISA_VALUE(MISA)) dut (
    .clk_i(clk), .rst_i(rst),
    .csr_access_i(csr_access), .csr_op_i(csr_op), .csr_addr_i(csr_addr),
    .csr_wdata_i(csr_wdata), .csr_rdata_o(csr_rdata), .csr_illegal_o(csr_illegal),
    .save_pc_ex_i(save_ex), .save_pc_id_i(save_id), .pc_ex_i(pc_ex), .pc_id_i(pc_id),
    .exception_cause_i(cause), .is_mret_i(mret), .instr_retired_i(retired),
    .trap_vector_o(trap_vector), .mepc_o(mepc), .mie_o(mie)
  );

  typedef struct {
    logic [31:0] rdata;
    logic        illegal;
    logic [31:0] tvec;
    logic [31:0] mepc;
    logic        mie;
    int          idx;
  } exp_t;

  exp_t q[$];
  int n_vec = 0;
  int n_err = 0;
  int vec_idx = 0;

  // Reference state, held as plain architectural values.
  bit          m_mie, m_mpie;
  logic [31:0] m_mtvec, m_mscratch, m_mepc;
  logic [4:0]  m_mcause;
  logic [63:0] m_cycle, m_instret;

  function automatic void model_reset();
    m_mie = 0; m_mpie = 0;
    m_mtvec = 32'h100; m_mscratch = 0; m_mepc = 0; m_mcause = 0;
    m_cycle = 0; m_instret = 0;
  endfunction

  function automatic void model_read(input logic [11:0] a, output bit mp, output logic [31:0] v);
    mp = 1;
    case (a)
      12'h300: v = 32'h1800 + (m_mpie ? 32'h80 : 32'h0) + (m_mie ? 32'h8 : 32'h0);
      12'h301: v = MISA;
      12'h305: v = m_mtvec;
      12'h340: v = m_mscratch;
      12'h341: v = m_mepc;
      12'h342: v = {27'b0, m_mcause};
      12'hB00, 12'hC00: v = m_cycle[31:0];
      12'hB80, 12'hC80: v = m_cycle[63:32];
      12'hB02, 12'hC02: v = m_instret[31:0];
      12'hB82, 12'hC82: v = m_instret[63:32];
      12'hF14: v = HART;
      default: begin mp = 0; v = 0; end
    endcase
  endfunction

  function automatic void model_step(input logic [31:0] old, input bit ill);
    logic [31:0] w;
    logic [63:0] cyc, ins;
    bit trap;
    trap = save_ex || save_id;
    cyc = m_cycle + 1;
    ins = m_instret + ((retired && !trap) ? 64'd1 : 64'd0);
    if (trap) begin
      m_mepc   = (save_ex ? pc_ex : pc_id) & 32'hFFFF_FFFC;
      m_mcause = cause;
      m_mpie   = m_mie;
      m_mie    = 0;
    end else if (mret) begin
      m_mie  = m_mpie;
      m_mpie = 1;
    end else if (csr_access && !ill && csr_op != 0) begin
      if (csr_op == 1)      w = csr_wdata;
      else if (csr_op == 2) w = old | csr_wdata;
      else                  w = old & ~csr_wdata;
      case (csr_addr)
        12'h300: begin m_mie = w[3]; m_mpie = w[7]; end
        12'h305: m_mtvec = w & 32'hFFFF_FFFC;
        12'h340: m_mscratch = w;
        12'h341: m_mepc = w & 32'hFFFF_FFFC;
        12'h342: m_mcause = w[4:0];
        12'hB00: cyc = {cyc[63:32], w};
        12'hB80: cyc = {w, cyc[31:0]};
        12'hB02: ins = {ins[63:32], w};
        12'hB82: ins = {w, ins[31:0]};
        default: ;
      endcase
    end
    m_cycle = cyc;
    m_instret = ins;
  endfunction

  // Predict this cycle's outputs, advance the model across the edge, then clear inputs.
  task automatic apply();
    exp_t e;
    bit mp;
    logic [31:0] old;
    if (rst) model_reset();
    model_read(csr_addr, mp, old);
    e.rdata   = old;
    e.illegal = csr_access && (!mp || (csr_op != 0 && csr_addr[11:10] == 2'b11));
    e.tvec    = m_mtvec;
    e.mepc    = m_mepc;
    e.mie     = m_mie;
    e.idx     = vec_idx++;
    q.push_back(e);
    if (!rst) model_step(old, e.illegal);
    @(posedge clk);
    #1;
    rst = 0; csr_access = 0; csr_op = 0; csr_addr = 0; csr_wdata = 0;
    save_ex = 0; save_id = 0; pc_ex = 0; pc_id = 0; cause = 0; mret = 0; retired = 0;
  endtask

  task automatic csr(input logic [1:0] op, input logic [11:0] a, input logic [31:0] d);
    csr_access = 1; csr_op = op; csr_addr = a; csr_wdata = d;
    apply();
  endtask

  task automatic chk(input string nm, input int idx, input logic [31:0] got, input logic [31:0] exp);
    n_vec++;
    if (got !== exp) begin
      n_err++;
      $display("FAIL %s vec %0d: got %h expected %h", nm, idx, got, exp);
    end
  endtask

  initial begin
    exp_t e;
    forever begin
      @(negedge clk);
      if (q.size() > 0) begin
        e = q.pop_front();
        chk("rdata", e.idx, csr_rdata, e.rdata);
        chk("illegal", e.idx, {31'b0, csr_illegal}, {31'b0, e.illegal});
        chk("trap_vector", e.idx, trap_vector, e.tvec);
        chk("mepc", e.idx, mepc, e.mepc);
        chk("mie", e.idx, {31'b0, mie}, {31'b0, e.mie});
      end
    end
  end

  logic [11:0] addrs [18] = '{12'h300, 12'h301, 12'h305, 12'h340, 12'h341, 12'h342,
                              12'hB00, 12'hB80, 12'hB02, 12'hB82, 12'hC00, 12'hC80,
                              12'hC02, 12'hC82, 12'hF14, 12'h7C0, 12'h344, 12'h003};

  initial begin
    model_reset();
    repeat (2) @(posedge clk);
    #1 rst = 0;

    csr(2'b00, 12'h300, 0);
    csr(2'b01, 12'h305, 32'h8000_0203);
    csr(2'b00, 12'h305, 0);
    csr(2'b10, 12'h300, 32'h8);
    save_id = 1; pc_id = 32'h44; cause = 5'd2; apply();
    csr(2'b00, 12'h341, 0);
    csr(2'b00, 12'h342, 0);
    mret = 1; apply();
    csr(2'b00, 12'h300, 0);
    save_ex = 1; pc_ex = 32'h30; save_id = 1; pc_id = 32'h34; cause = 5'd0;
    csr_access = 1; csr_op = 2'b01; csr_addr = 12'h340; csr_wdata = 32'hDEAD_BEEF; apply();
    csr(2'b00, 12'h340, 0);
    csr(2'b00, 12'h342, 0);
    csr(2'b01, 12'hB00, 32'hFFFF_FFFF);
    apply();
    csr(2'b00, 12'hB00, 0);
    csr(2'b00, 12'hB80, 0);
    csr(2'b01, 12'hF14, 32'h1234);
    csr(2'b00, 12'h7C0, 0);
    csr(2'b00, 12'hF14, 0);
    csr(2'b01, 12'h301, 32'hFFFF_FFFF);
    csr(2'b11, 12'hC00, 32'h1);

    // Reset landing on a trap cycle must leave only reset values.
    rst = 1; save_ex = 1; pc_ex = 32'h80; cause = 5'd7; apply();
    csr(2'b00, 12'h300, 0);

    repeat (500) begin
      csr_access = ($urandom_range(0, 3) != 0);
      csr_op     = 2'($urandom);
      csr_addr   = addrs[$urandom_range(0, 17)];
      csr_wdata  = $urandom;
      save_ex    = ($urandom_range(0, 15) == 0);
      save_id    = ($urandom_range(0, 15) == 0);
      pc_ex      = $urandom;
      pc_id      = $urandom;
      cause      = 5'($urandom);
      mret       = ($urandom_range(0, 9) == 0);
      retired    = 1'($urandom);
      apply();
    end

    repeat (2) @(negedge clk);
    if (q.size() != 0) begin
      n_err++;
      $display("FAIL drain: got %0d pending expected 0", q.size());
    end
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
